wifi_cmd_arbiter: RTL

//  Shares the security FSM's 4-bit inWIFI command port between N_REQ requesters (app link, keypad, panel, ...).

---
 rtl/wifi_cmd_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/wifi_cmd_arbiter.sv
// wifi_cmd_arbiter: shares the security FSM's 4-bit inWIFI command port between
// N_REQ requesters. Round-robin grant, fixed hold/gap framing of each command,
// and an escalation timer that injects EMERGENCY after a long silent ALARM.
module wifi_cmd_arbiter #(
  parameter int N_REQ       = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int ESC_TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [4*N_REQ-1:0] req_cmd,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               alarm_n,
  output logic [3:0]         cmd_out,
  output logic               cmd_strobe,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic               reject,
  output logic               esc_fired
);

  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int ESC_W   = $clog2(ESC_TIMEOUT);

  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [ESC_W-1:0] ESC_SAT   = ESC_W'(ESC_TIMEOUT - 1);
  localparam logic [3:0]       CMD_EMERG = 4'b1100;
  localparam logic [1:0]       GID_ESC   = 2'b11;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [PTR_W-1:0] rr_ptr;
  logic [ESC_W-1:0] esc_cnt;
  logic             esc_pending;

  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;
  logic [N_REQ-1:0] sel_onehot;
  logic [3:0]       sel_cmd;
  logic [PTR_W-1:0] rr_next;
  logic             esc_grant;
  logic             ext_grant;

  // Only DISARM, REARM and EMERGENCY may reach the security FSM.
  function automatic logic is_legal(input logic [3:0] c);
    return (c == 4'b1010) || (c == 4'b1011) || (c == 4'b1100);
  endfunction

  // Round-robin pick: first valid index at or above the pointer, else wrap to the lowest valid.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    sel_cmd    = 4'b0000;
    for (int i = 0; i < N_REQ; i++) begin
      if (!sel_found && req_valid[i] && (PTR_W'(i) >= rr_ptr)) begin
        sel_found     = 1'b1;
        sel_idx       = PTR_W'(i);
        sel_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!sel_found && req_valid[i]) begin
        sel_found     = 1'b1;
        sel_idx       = PTR_W'(i);
        sel_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == PTR_W'(i)) sel_cmd = req_cmd[4*i +: 4];
    end
    rr_next   = (sel_idx == PTR_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
    esc_grant = (state == IDLE) && esc_pending;
    ext_grant = (state == IDLE) && !esc_pending && sel_found && is_legal(sel_cmd);
  end

  // Command framing FSM: grant in IDLE, drive for HOLD_CYCLES, idle for GAP_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tmr        <= '0;
      rr_ptr     <= '0;
      cmd_out    <= 4'b0000;
      cmd_strobe <= 1'b0;
      req_ready  <= '0;
      grant_id   <= 2'b00;
      busy       <= 1'b0;
      reject     <= 1'b0;
      esc_fired  <= 1'b0;
    end else begin
      cmd_strobe <= 1'b0;
      req_ready  <= '0;
      reject     <= 1'b0;
      esc_fired  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (esc_pending) begin
            // Escalation outranks every requester and leaves the rotation untouched.
            cmd_out    <= CMD_EMERG;
            grant_id   <= GID_ESC;
            esc_fired  <= 1'b1;
            cmd_strobe <= 1'b1;
            busy       <= 1'b1;
            tmr        <= HOLD_LOAD;
            state      <= HOLD;
          end else if (sel_found) begin
            req_ready <= sel_onehot;
            rr_ptr    <= rr_next;
            if (is_legal(sel_cmd)) begin
              cmd_out    <= sel_cmd;
              grant_id   <= 2'(sel_idx);
              cmd_strobe <= 1'b1;
              busy       <= 1'b1;
              tmr        <= HOLD_LOAD;
              state      <= HOLD;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (tmr == '0) begin
            cmd_out <= 4'b0000;
            tmr     <= GAP_LOAD;
            state   <= GAP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        GAP: begin
          if (tmr == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Escalation timer: counts silent ALARM cycles, saturates, and latches a pending EMERGENCY.
  always_ff @(posedge clk) begin
    if (reset) begin
      esc_cnt     <= '0;
      esc_pending <= 1'b0;
    end else if (esc_grant) begin
      esc_cnt     <= '0;
      esc_pending <= 1'b0;
    end else if (ext_grant) begin
      esc_cnt <= '0;
    end else if (alarm_n) begin
      esc_cnt     <= '0;
      esc_pending <= 1'b0;
    end else if (esc_cnt != ESC_SAT) begin
      esc_cnt <= esc_cnt + 1'b1;
      if (esc_cnt == ESC_SAT - 1'b1) esc_pending <= 1'b1;
    end
  end

endmodule
